// File: rtl/sipo_deframer.sv
// Serial-to-parallel receive stage: frame-start aligned word assembly with a
// registered valid/ready output and sticky overrun / framing-error flags.
module sipo_deframer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx, sr_shift, out_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             complete, valid_nx, ovr_nx, ferr_nx;

  // Shift register contents after absorbing the current serial bit.
  always_comb begin
    if (MSB_FIRST) begin
      sr_shift = {sr[WIDTH-2:0], serial_in};
    end else begin
      sr_shift = {serial_in, sr[WIDTH-1:1]};
    end
  end

  // Next-state, word assembly and output-register decisions.
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    complete = 1'b0;
    ferr_nx  = frame_err;
    out_nx   = data_out;
    valid_nx = data_valid;
    ovr_nx   = overrun;

    case (state)
      IDLE: begin
        if (bit_valid && frame_start) begin
          sr_nx    = sr_shift;
          cnt_nx   = CW'(1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          sr_nx = sr_shift;
          if (frame_start) begin
            ferr_nx = 1'b1;
            cnt_nx  = CW'(1);
          end else if (cnt == CW'(WIDTH - 1)) begin
            complete = 1'b1;
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // An accept and a completion on the same edge reload without a bubble.
    if (complete) begin
      if (!data_valid || data_ready) begin
        out_nx   = sr_shift;
        valid_nx = 1'b1;
      end else begin
        ovr_nx = 1'b1;
      end
    end else if (data_valid && data_ready) begin
      valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      sr         <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sr         <= sr_nx;
      cnt        <= cnt_nx;
      data_out   <= out_nx;
      data_valid <= valid_nx;
      overrun    <= ovr_nx;
      frame_err  <= ferr_nx;
    end
  end

endmodule

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-to-parallel receive stage sitting directly downstream of the 8-bit PISO shifter. It samples the serial bit stream under a per-bit valid strobe and aligns words on a frame-start marker. Completed words are presented on a parallel output register with a valid/ready handshake. Framing and overrun errors are flagged as sticky bits for the consuming logic.

## Interface
- `WIDTH`, default 8: bits per word; legal values are 2..32.
- `MSB_FIRST`, default 1:
  - 1: the first received bit lands in `data_out[WIDTH-1]`.
  - 0: the first received bit lands in `data_out[0]`.

Ports:
- `clk`: input, 1 bit. Single clock; all logic on the rising edge.
- `clr`: input, 1 bit. Synchronous, active-low reset.
- `serial_in`: input, 1 bit. Serial data bit.
- `bit_valid`: input, 1 bit. `serial_in` is sampled only when this is 1.
- `frame_start`: input, 1 bit. Marks the current valid bit as the first bit of a word. Ignored unless `bit_valid` is 1.
- `data_out`: output, `WIDTH` bits. Assembled word.
- `data_valid`: output, 1 bit. `data_out` holds an unconsumed word.
- `data_ready`: input, 1 bit. Consumer accepts `data_out` on a cycle where `data_valid` and `data_ready` are both 1.
- `overrun`: output, 1 bit. Sticky: a completed word was dropped.
- `frame_err`: output, 1 bit. Sticky: a partial word was aborted by a new `frame_start`.

## Operation
- **State machine:** two states, IDLE and SHIFT. Internal `WIDTH`-bit shift register `sr`. Bit counter `cnt` of width `$clog2(WIDTH+1)`.
- **IDLE:**
  - `bit_valid` with `frame_start`=0: ignored.
  - `bit_valid` with `frame_start`=1: the bit is shifted into `sr`, `cnt`=1, go to SHIFT.
- **SHIFT:**
  - Each `bit_valid` with `frame_start`=0 shifts `serial_in` into `sr` and increments `cnt`.
  - If `MSB_FIRST`=1, shift left with the new bit at position 0. If `MSB_FIRST`=0, shift right with the new bit at position `WIDTH-1`.
- **Word complete:** occurs when a valid bit makes `cnt` reach `WIDTH`. On that same edge:
  - the assembled word, including this bit, is offered to the output register;
  - `cnt` returns to 0 and the state returns to IDLE.
  - The next word always requires a fresh `frame_start`.
- **Restart:** `frame_start`=1 with `bit_valid` while in SHIFT:
  - the partial word is discarded and `frame_err` is set;
  - the current bit is taken as bit 1 of the new word, `cnt`=1, and the state stays SHIFT.
- **Gaps:** `bit_valid`=0 in SHIFT holds `sr`, `cnt` and state. There is no timeout.
- **Output register, evaluated each edge:**
  - Word complete and (`data_valid`=0 or `data_ready`=1): `data_out` is loaded and `data_valid` is 1.
  - Word complete, `data_valid`=1 and `data_ready`=0: the new word is dropped, `data_out` is unchanged and `overrun` is set.
  - No completion, `data_valid`=1 and `data_ready`=1: `data_valid` goes to 0; `data_out` holds its last value.
- **Sticky flags:** `overrun` and `frame_err` clear only on reset.

## Timing
- **Reset:** `clr`=0 at an edge forces:
  - state IDLE, `sr`=0, `cnt`=0;
  - `data_out`=0, `data_valid`=0, `overrun`=0, `frame_err`=0.
  - This applies mid-word as well; the partial word is lost and no flag is set.
  - Inputs are ignored while `clr`=0.
- **Latency:** if the first bit (with `frame_start`) is sampled at edge N and bits are back-to-back, `data_valid` rises after edge N+WIDTH-1 and is visible in the following cycle.
- **Throughput:** one word per `WIDTH` cycles at full rate, provided the consumer holds `data_ready`=1.
- **Same-edge accept and complete:** when an accept and a completion fall on the same edge, `data_valid` stays 1 with the new word, without a gap.
- **No combinational paths:** all outputs are registered. There is no combinational path from `data_ready` to `data_valid`.

## Test plan
1. **Reset values:** hold `clr`=0 for 3 cycles, then drive `bit_valid`=1 with `frame_start`=0 for 10 cycles.
   - Required: all outputs stay 0 and the block remains in IDLE.
2. **Basic word:** `WIDTH`=8, `MSB_FIRST`=1, `data_ready`=1. Send bits 0,0,0,0,1,1,1,1 back-to-back, `frame_start` on the first bit.
   - Required: `data_out`=8'h0F; `data_valid` high for exactly 1 cycle, 8 cycles after the first bit.
3. **Back-to-back words with a gap:** send 8'hFF, then 8'h80 with `bit_valid`=0 for 3 cycles mid-word.
   - Required: outputs 8'hFF then 8'h80; `overrun`=0 and `frame_err`=0.
4. **Overrun:** hold `data_ready`=0; send 8'hA5, then 8'h3C.
   - Required: `data_out` stays 8'hA5 and `overrun`=1.
   - Then raise `data_ready` for 1 cycle. Required: `data_valid`=0 and `overrun` stays 1.
5. **Restart:** send 5 bits of 8'hFF, then `frame_start` with the full 8 bits of 8'h5A.
   - Required: output 8'h5A only; `frame_err`=1.
6. **Reset mid-word and `MSB_FIRST`=0:** pulse `clr`=0 after 4 bits, then send 8'h01 with `MSB_FIRST`=0, bit order 1,0,0,0,0,0,0,0.
   - Required: `data_out`=8'h01; `frame_err`=0 and `overrun`=0.
